wbs_uart_tx: RTL and testbench

Wishbone B4 pipelined slave that buffers bytes in a FIFO and serialises them as 8N1 UART frames on one output pin. It sits directly downstream of the SPI-controlled Wishbone master, so the MCU can print through the FPGA with SPI register writes. Register map: DATA, STATUS and DIVISOR, all 32-bit word-aligned.

---
 rtl/wbs_uart_tx.sv | 198 +++++++++++++++++++
 tb/tb_wbs_uart_tx.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wbs_uart_tx.sv
// wbs_uart_tx: Wishbone B4 pipelined slave feeding a FIFO-buffered 8N1 UART transmitter.
// Define WBS_UART_TX_STALL_EN to stall DATA writes while the FIFO is full instead of dropping them.
module wbs_uart_tx #(
    parameter int FIFO_DEPTH    = 16,
    parameter int DIVISOR_RESET = 103
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic        wb_we_i,
    input  logic [3:0]  wb_sel_i,
    input  logic [15:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_stall_o,
    output logic        wb_ack_o,
    output logic        uart_tx
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    logic             req, wr_req, rd_req;
    logic             data_sel, stat_sel, div_sel;
    logic             fifo_empty, fifo_full, push, pop, busy, bit_end;
    logic             ovf_set, ovf_clr;
    logic [7:0]       fifo_rdata;
    logic [31:0]      status;
    logic             unused_ok;

    logic             ack_q, ack_d, ovf_q, ovf_d;
    logic [31:0]      dat_q, dat_d;
    logic [15:0]      div_q, div_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic [7:0]       mem_q [FIFO_DEPTH];

    state_t           state_q, state_d;
    logic [7:0]       shift_q, shift_d;
    logic [2:0]       idx_q, idx_d;
    logic [15:0]      cnt_q, cnt_d, bdiv_q, bdiv_d;

    assign unused_ok = ^{wb_adr_i[15:4], wb_adr_i[1:0], wb_dat_i[31:16], wb_sel_i[3:2]};

    assign data_sel = (wb_adr_i[3:2] == 2'd0);
    assign stat_sel = (wb_adr_i[3:2] == 2'd1);
    assign div_sel  = (wb_adr_i[3:2] == 2'd2);

`ifdef WBS_UART_TX_STALL_EN
    assign wb_stall_o = wb_cyc_i && wb_stb_i && wb_we_i && data_sel && wb_sel_i[0] && fifo_full;
`else
    assign wb_stall_o = 1'b0;
`endif

    assign req    = wb_cyc_i && wb_stb_i && !wb_stall_o;
    assign wr_req = req && wb_we_i;
    assign rd_req = req && !wb_we_i;

    assign fifo_empty = (level_q == '0);
    assign fifo_full  = (level_q == LVL_W'(FIFO_DEPTH));
    assign fifo_rdata = mem_q[rd_ptr_q];

    // A full FIFO refuses the push even if the transmitter pops in the same cycle.
    assign push    = wr_req && data_sel && wb_sel_i[0] && !fifo_full;
    assign ovf_set = wr_req && data_sel && wb_sel_i[0] && fifo_full;
    assign ovf_clr = wr_req && stat_sel && wb_sel_i[0] && wb_dat_i[3];

    always_comb begin
        div_d = div_q;
        if (wr_req && div_sel) begin
            if (wb_sel_i[0]) div_d[7:0]  = wb_dat_i[7:0];
            if (wb_sel_i[1]) div_d[15:8] = wb_dat_i[15:8];
        end
        ovf_d = (ovf_q && !ovf_clr) || ovf_set;

        status       = '0;
        status[0]    = fifo_empty;
        status[1]    = fifo_full;
        status[2]    = busy;
        status[3]    = ovf_q;
        status[15:8] = 8'(level_q);

        dat_d = '0;
        if (rd_req) begin
            if (stat_sel)     dat_d = status;
            else if (div_sel) dat_d = {16'h0, div_q};
        end
        ack_d = req;

        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        level_d  = level_q;
        if (push && !pop)      level_d = level_q + 1'b1;
        else if (!push && pop) level_d = level_q - 1'b1;
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            ack_q    <= 1'b0;
            dat_q    <= '0;
            div_q    <= 16'(DIVISOR_RESET);
            ovf_q    <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            ack_q    <= ack_d;
            dat_q    <= dat_d;
            div_q    <= div_d;
            ovf_q    <= ovf_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (push) mem_q[wr_ptr_q] <= wb_dat_i[7:0];
        shift_q <= shift_d;
        bdiv_q  <= bdiv_d;
    end

    assign wb_ack_o = ack_q;
    assign wb_dat_o = dat_q;

    // Transmitter state register
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bit_end = (cnt_q == '0);

    // Popping at the end of a stop bit chains frames with no idle gap.
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        bdiv_d  = bdiv_q;
        if (pop) begin
            state_d = S_START;
            shift_d = fifo_rdata;
            cnt_d   = div_q;
            bdiv_d  = div_q;
        end else begin
            case (state_q)
                S_START: begin
                    if (bit_end) begin
                        state_d = S_DATA;
                        idx_d   = '0;
                        cnt_d   = bdiv_q;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                S_DATA: begin
                    if (bit_end) begin
                        shift_d = {1'b0, shift_q[7:1]};
                        idx_d   = idx_q + 1'b1;
                        cnt_d   = bdiv_q;
                        if (idx_q == 3'd7) state_d = S_STOP;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                S_STOP: begin
                    if (bit_end) state_d = S_IDLE;
                    else         cnt_d   = cnt_q - 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        uart_tx = 1'b1;
        pop     = 1'b0;
        busy    = (state_q != S_IDLE);
        case (state_q)
            S_IDLE:  pop     = !fifo_empty;
            S_START: uart_tx = 1'b0;
            S_DATA:  uart_tx = shift_q[0];
            S_STOP:  pop     = bit_end && !fifo_empty;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_wbs_uart_tx.sv
// Directed self-checking bench for wbs_uart_tx: registers, frame timing, FIFO limits, reset.
module tb_wbs_uart_tx;
    localparam int DEPTH   = 16;
    localparam int DIV_RST = 103;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
    logic [3:0]  sel = 4'h0;
    logic [15:0] adr = 16'h0;
    logic [31:0] dat_i = 32'h0;
    logic [31:0] dat_o;
    logic        stall, ack, tx;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    wbs_uart_tx #(.FIFO_DEPTH(DEPTH), .DIVISOR_RESET(DIV_RST)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we),
        .wb_sel_i(sel), .wb_adr_i(adr), .wb_dat_i(dat_i), .wb_dat_o(dat_o),
        .wb_stall_o(stall), .wb_ack_o(ack), .uart_tx(tx)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] tbyte(input int i);
        return 8'(8'h31 + i * 7);
    endfunction

    // Single request; ok = no ack before acceptance and ack exactly one cycle after it.
    task automatic bus(input logic w, input logic [15:0] a, input logic [31:0] d,
                       input logic [3:0] s, output logic [31:0] rd, output logic ok);
        int n;
        n = 0;
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_i = d; sel = s;
        while (stall === 1'b1 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        ok = (ack === 1'b0) && (n < 5000);
        @(posedge clk);
        @(negedge clk);
        ok = ok && (ack === 1'b1);
        rd = dat_o;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    // Back-to-back DATA writes of tbyte(0..n-1), one request per cycle while not stalled.
    task automatic burst(input int n, output int acks, output int stalls, output int lat_err);
        int  i, guard;
        logic acc;
        i = 0; guard = 0; acks = 0; stalls = 0; lat_err = 0;
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 16'h0; sel = 4'h1; dat_i = {24'h0, tbyte(0)};
        while (i < n && guard < 5000) begin
            acc = (stall !== 1'b1);
            if (!acc) stalls++;
            @(posedge clk);
            @(negedge clk);
            if (ack === 1'b1) acks++;
            if (ack !== acc) lat_err++;
            if (acc) begin
                i++;
                dat_i = {24'h0, tbyte(i)};
            end
            guard++;
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    task automatic test_reset;
        logic [31:0] r;
        logic        ok;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (ack !== 1'b0 || stall !== 1'b0 || dat_o !== 32'h0 || tx !== 1'b1)
            $display("FAIL reset_outputs: ack=%b stall=%b dat=%h tx=%b, expected 0 0 00000000 1",
                     ack, stall, dat_o, tx);
        rst = 1'b0;
        bus(1'b0, 16'h4, 32'h0, 4'hF, r, ok);
        checks++;
        if (!ok || r !== 32'h1) begin
            errors++;
            $display("FAIL reset_status: ack_ok=%b dat=%h, expected ack_ok=1 dat=00000001", ok, r);
        end
        bus(1'b0, 16'h8, 32'h0, 4'hF, r, ok);
        checks++;
        if (!ok || r !== 32'(DIV_RST)) begin
            errors++;
            $display("FAIL reset_divisor: ack_ok=%b dat=%h, expected ack_ok=1 dat=%h", ok, r, 32'(DIV_RST));
        end
        checks++;
        if (tx !== 1'b1) begin
            errors++;
            $display("FAIL reset_tx_idle: tx=%b, expected 1", tx);
        end
    endtask

    task automatic test_frame;
        logic [31:0] r;
        logic        ok;
        logic [41:0] act, exp;
        logic [9:0]  frame;
        frame = {1'b1, 8'h55, 1'b0};
        bus(1'b1, 16'h8, 32'd3, 4'h3, r, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL frame_div_write_ack: ack_ok=%b, expected 1", ok);
        end
        bus(1'b1, 16'h0, 32'h55, 4'h1, r, ok);
        checks++;
        if (!ok || tx !== 1'b1) begin
            errors++;
            $display("FAIL frame_data_write: ack_ok=%b tx=%b, expected ack_ok=1 tx=1", ok, tx);
        end
        for (int k = 0; k < 42; k++) begin
            @(negedge clk);
            act[k] = tx;
            exp[k] = (k < 40) ? frame[k / 4] : 1'b1;
        end
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL frame_0x55_div3: got %h, expected %h (bit k = clock k after pop)", act, exp);
        end
        bus(1'b0, 16'h4, 32'h0, 4'hF, r, ok);
        checks++;
        if (!ok || r !== 32'h1) begin
            errors++;
            $display("FAIL frame_status_after: ack_ok=%b dat=%h, expected 1 00000001", ok, r);
        end
    endtask

    task automatic test_div_mid_frame;
        logic [31:0] r;
        logic        ok, ok1, ok2;
        logic [99:0] act, exp;
        logic [9:0]  f1, f2;
        f1 = {1'b1, 8'hA5, 1'b0};
        f2 = {1'b1, 8'h3C, 1'b0};
        ok1 = 1'b0; ok2 = 1'b0;
        bus(1'b1, 16'h0, 32'hA5, 4'h1, r, ok);
        fork
            for (int k = 0; k < 100; k++) begin
                @(negedge clk);
                act[k] = tx;
            end
            begin
                logic [31:0] r1;
                bus(1'b1, 16'h8, 32'd1, 4'h3, r1, ok1);
                bus(1'b1, 16'h0, 32'h3C, 4'h1, r1, ok2);
            end
        join
        for (int k = 0; k < 100; k++)
            exp[k] = (k < 40) ? f1[k / 4] : (k < 60) ? f2[(k - 40) / 2] : 1'b1;
        checks++;
        if (!ok || !ok1 || !ok2) begin
            errors++;
            $display("FAIL middiv_acks: acks=%b%b%b, expected 111", ok, ok1, ok2);
        end
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL middiv_frames: got %h, expected %h", act, exp);
        end
    endtask

    task automatic test_overflow;
        logic [31:0] r;
        logic        ok;
        int          acks, stalls, lat;
        bus(1'b1, 16'h8, 32'd1000, 4'h3, r, ok);
        burst(17, acks, stalls, lat);
        // First byte leaves for the shift register right away, so 17 writes leave 16 queued.
        checks++;
        if (acks !== 17 || lat !== 0 || stalls !== 0) begin
            errors++;
            $display("FAIL ovf_burst: acks=%0d lat_err=%0d stalls=%0d, expected 17 0 0", acks, lat, stalls);
        end
        bus(1'b0, 16'h4, 32'h0, 4'hF, r, ok);
        checks++;
        if (!ok || r !== 32'h0000_1006) begin
            errors++;
            $display("FAIL ovf_full_status: ack_ok=%b dat=%h, expected 1 00001006", ok, r);
        end
        bus(1'b1, 16'h0, {24'h0, tbyte(17)}, 4'h1, r, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL ovf_dropped_write_ack: ack_ok=%b, expected 1", ok);
        end
        bus(1'b0, 16'h4, 32'h0, 4'hF, r, ok);
        checks++;
        if (!ok || r !== 32'h0000_100E) begin
            errors++;
            $display("FAIL ovf_set_status: ack_ok=%b dat=%h, expected 1 0000100e", ok, r);
        end
        bus(1'b1, 16'h4, 32'h8, 4'h1, r, ok);
        bus(1'b0, 16'h4, 32'h0, 4'hF, r, ok);
        checks++;
        if (!ok || r !== 32'h0000_1006) begin
            errors++;
            $display("FAIL ovf_clear_status: ack_ok=%b dat=%h, expected 1 00001006", ok, r);
        end
        bus(1'b1, 16'h0, 32'h77, 4'h2, r, ok);
        bus(1'b0, 16'h4, 32'h0, 4'hF, r, ok);
        checks++;
        if (!ok || r !== 32'h0000_1006) begin
            errors++;
            $display("FAIL ovf_nosel0_ignored: ack_ok=%b dat=%h, expected 1 00001006", ok, r);
        end
    endtask

    task automatic test_stall;
        logic [31:0] r;
        logic        ok;
        int          acks, stalls, lat, nrx, bad_frame, bad_byte;
        logic [7:0]  got [18];
        nrx = 0; bad_frame = 0; bad_byte = 0;
        bus(1'b1, 16'h8, 32'd3, 4'h3, r, ok);
        fork
            burst(18, acks, stalls, lat);
            begin
                for (int f = 0; f < 18; f++) begin
                    int n;
                    n = 0;
                    @(negedge clk);
                    while (tx !== 1'b0 && n < 400) begin
                        @(negedge clk);
                        n++;
                    end
                    if (n >= 400) break;
                    repeat (2) @(negedge clk);
                    if (tx !== 1'b0) bad_frame++;
                    for (int b = 0; b < 8; b++) begin
                        repeat (4) @(negedge clk);
                        got[f][b] = tx;
                    end
                    repeat (4) @(negedge clk);
                    if (tx !== 1'b1) bad_frame++;
                    nrx++;
                end
            end
        join
        checks++;
        if (acks !== 18 || lat !== 0) begin
            errors++;
            $display("FAIL stall_burst_acks: acks=%0d lat_err=%0d, expected 18 0", acks, lat);
        end
        checks++;
        if (stalls < 1) begin
            errors++;
            $display("FAIL stall_seen: stall_cycles=%0d, expected at least 1", stalls);
        end
        for (int i = 0; i < 18; i++)
            if (i < nrx && got[i] !== tbyte(i)) bad_byte++;
        checks++;
        if (nrx !== 18 || bad_frame !== 0 || bad_byte !== 0) begin
            errors++;
            $display("FAIL stall_rx_order: frames=%0d bad_framing=%0d bad_bytes=%0d, expected 18 0 0",
                     nrx, bad_frame, bad_byte);
        end
        repeat (4) @(negedge clk);
        bus(1'b0, 16'h4, 32'h0, 4'hF, r, ok);
        checks++;
        if (!ok || r !== 32'h1) begin
            errors++;
            $display("FAIL stall_status_after: ack_ok=%b dat=%h, expected 1 00000001", ok, r);
        end
    endtask

    task automatic test_reset_mid_frame;
        logic [31:0] r;
        logic        ok;
        int          n;
        bus(1'b1, 16'h8, 32'd1000, 4'h3, r, ok);
        bus(1'b1, 16'h0, 32'h00, 4'h1, r, ok);
        n = 0;
        while (tx !== 1'b0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (tx !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_frame_running: tx=%b, expected 0", tx);
        end
        #1 rst = 1'b1;
        #1;
        checks++;
        if (tx !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_tx_async: tx=%b, expected 1", tx);
        end
        @(negedge clk);
        rst = 1'b0;
        bus(1'b0, 16'h4, 32'h0, 4'hF, r, ok);
        checks++;
        if (!ok || r !== 32'h1) begin
            errors++;
            $display("FAIL rstmid_status: ack_ok=%b dat=%h, expected 1 00000001", ok, r);
        end
        bus(1'b0, 16'h0, 32'h0, 4'hF, r, ok);
        checks++;
        if (!ok || r !== 32'h0) begin
            errors++;
            $display("FAIL rstmid_read_data: ack_ok=%b dat=%h, expected 1 00000000", ok, r);
        end
        bus(1'b1, 16'hC, 32'hFFFF_FFFF, 4'hF, r, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL rstmid_write_unmapped_ack: ack_ok=%b, expected 1", ok);
        end
        bus(1'b0, 16'hC, 32'h0, 4'hF, r, ok);
        checks++;
        if (!ok || r !== 32'h0) begin
            errors++;
            $display("FAIL rstmid_read_unmapped: ack_ok=%b dat=%h, expected 1 00000000", ok, r);
        end
        bus(1'b0, 16'h8, 32'h0, 4'hF, r, ok);
        checks++;
        if (!ok || r !== 32'(DIV_RST)) begin
            errors++;
            $display("FAIL rstmid_divisor: ack_ok=%b dat=%h, expected 1 %h", ok, r, 32'(DIV_RST));
        end
    endtask

    initial begin
        test_reset();
        test_frame();
        test_div_mid_frame();
`ifdef WBS_UART_TX_STALL_EN
        test_stall();
`else
        test_overflow();
`endif
        test_reset_mid_frame();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
